// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access width codes and the queued request payload.
package lsu_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_WB   = 2'd3
  } lsu_state_e;

  localparam logic LSU_BYTE = 1'b0;
  localparam logic LSU_WORD = 1'b1;

  typedef struct packed {
    logic              st;
    logic              width;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } lsu_req_t;

endpackage

// File: rtl/lsu_req_fifo.sv
// In-order request queue; also reports whether any queued entry will be a store after this edge.
module lsu_req_fifo
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 2
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             push,
  input  lsu_req_t         push_req,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output lsu_req_t         head_req_c,
  output logic [TAG_W-1:0] head_tag_c,
  output logic             full,
  output logic             empty,
  output logic             st_any_nxt_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  lsu_req_t         mem_q [DEPTH];
  lsu_req_t         mem_d [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  assign head_req_c = mem_q[rptr_q];
  assign head_tag_c = tag_q[rptr_q];
  assign full       = full_q;
  assign empty      = empty_q;

  always_comb begin
    mem_d        = mem_q;
    tag_d        = tag_q;
    vld_d        = vld_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    st_any_nxt_c = 1'b0;
    do_push      = push & ~full_q;
    do_pop       = pop & ~empty_q;
    if (do_pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + PTR_W'(1);
    end
    if (do_push) begin
      mem_d[wptr_q] = push_req;
      tag_d[wptr_q] = push_tag;
      vld_d[wptr_q] = 1'b1;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d  = (cnt_d == CNT_W'(DEPTH));
    empty_d = (cnt_d == '0);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      st_any_nxt_c = st_any_nxt_c | (vld_d[i] & mem_d[i].st);
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        tag_q[i] <= '0;
      end
      vld_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      tag_q   <= tag_d;
      vld_q   <= vld_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: queues issued memory ops and runs them in order over a byte-wide bus.
// Bus outputs are registered from the next state so a new bus cycle starts on the pop edge.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 2
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             iss_valid,
  input  logic             iss_ld,
  input  logic             iss_st,
  input  logic             iss_width,
  input  logic [15:0]      iss_addr,
  input  logic [15:0]      iss_data,
  input  logic [TAG_W-1:0] iss_tag,
  output logic             iss_ready,
  output logic [15:0]      mem_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_ready,
  output logic [15:0]      lsu_data,
  output logic             lsu_wb,
  output logic [TAG_W-1:0] lsu_tag,
  output logic             lsu_st_pending
);

  lsu_state_e       state_q, state_d;
  lsu_req_t         wk_q, wk_d;
  logic [TAG_W-1:0] wk_tag_q, wk_tag_d;
  logic [BYTE_W-1:0] lo_q, lo_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BYTE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic             mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] lsu_data_q, lsu_data_d;
  logic [TAG_W-1:0] lsu_tag_q, lsu_tag_d;
  logic             lsu_wb_q, lsu_wb_d;
  logic             st_pend_q, st_pend_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_st_any;
  lsu_req_t         iss_req, head_req;
  logic [TAG_W-1:0] head_tag;
  logic             start;

  // Simultaneous ld and st is treated as a load.
  assign iss_req   = '{st: iss_st & ~iss_ld, width: iss_width, addr: iss_addr, data: iss_data};
  assign fifo_push = iss_valid & ~fifo_full;

  lsu_req_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo (
    .clk          (clk),
    .a_rst        (a_rst),
    .push         (fifo_push),
    .push_req     (iss_req),
    .push_tag     (iss_tag),
    .pop          (fifo_pop),
    .head_req_c   (head_req),
    .head_tag_c   (head_tag),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .st_any_nxt_c (fifo_st_any)
  );

  always_comb begin
    state_d     = state_q;
    wk_d        = wk_q;
    wk_tag_d    = wk_tag_q;
    lo_d        = lo_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    lsu_wb_d    = 1'b0;
    lsu_data_d  = lsu_data_q;
    lsu_tag_d   = lsu_tag_q;
    fifo_pop    = 1'b0;
    start       = 1'b0;
    unique case (state_q)
      ST_IDLE: start = ~fifo_empty;
      ST_LO: begin
        if (mem_ready) begin
          if (wk_q.width == LSU_WORD) begin
            state_d     = ST_HI;
            mem_addr_d  = wk_q.addr + ADDR_W'(1);
            mem_wdata_d = wk_q.data[15:8];
            mem_rd_d    = ~wk_q.st;
            mem_wr_d    = wk_q.st;
            lo_d        = mem_rdata;
          end else if (!wk_q.st) begin
            state_d    = ST_WB;
            lsu_wb_d   = 1'b1;
            lsu_data_d = {8'h00, mem_rdata};
            lsu_tag_d  = wk_tag_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          mem_rd_d = mem_rd_q;
          mem_wr_d = mem_wr_q;
        end
      end
      ST_HI: begin
        if (mem_ready) begin
          if (!wk_q.st) begin
            state_d    = ST_WB;
            lsu_wb_d   = 1'b1;
            lsu_data_d = {mem_rdata, lo_q};
            lsu_tag_d  = wk_tag_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          mem_rd_d = mem_rd_q;
          mem_wr_d = mem_wr_q;
        end
      end
      ST_WB: begin
        start   = ~fifo_empty;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Pop the head and launch its low-byte bus cycle on this edge.
    if (start) begin
      fifo_pop    = 1'b1;
      wk_d        = head_req;
      wk_tag_d    = head_tag;
      state_d     = ST_LO;
      mem_addr_d  = head_req.addr;
      mem_wdata_d = head_req.data[7:0];
      mem_rd_d    = ~head_req.st;
      mem_wr_d    = head_req.st;
    end
  end

  always_comb begin
    st_pend_d = fifo_st_any | (((state_d == ST_LO) || (state_d == ST_HI)) && wk_d.st);
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q     <= ST_IDLE;
      wk_q        <= '0;
      wk_tag_q    <= '0;
      lo_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      lsu_wb_q    <= 1'b0;
      lsu_data_q  <= '0;
      lsu_tag_q   <= '0;
      st_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wk_q        <= wk_d;
      wk_tag_q    <= wk_tag_d;
      lo_q        <= lo_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      lsu_wb_q    <= lsu_wb_d;
      lsu_data_q  <= lsu_data_d;
      lsu_tag_q   <= lsu_tag_d;
      st_pend_q   <= st_pend_d;
    end
  end

  assign iss_ready      = ~fifo_full;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_rd         = mem_rd_q;
  assign mem_wr         = mem_wr_q;
  assign lsu_wb         = lsu_wb_q;
  assign lsu_data       = lsu_data_q;
  assign lsu_tag        = lsu_tag_q;
  assign lsu_st_pending = st_pend_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-array bus responder with wait states, load-result scoreboard, vector table and corner sequences.
module tb_lsu;

  localparam int unsigned TAG_W = 2;
  localparam int unsigned DEPTH = 2;

  logic             clk, a_rst;
  logic             iss_valid, iss_ld, iss_st, iss_width, iss_ready;
  logic [15:0]      iss_addr, iss_data, mem_addr, lsu_data;
  logic [TAG_W-1:0] iss_tag, lsu_tag;
  logic             mem_rd, mem_wr, mem_ready, lsu_wb, lsu_st_pending;
  logic [7:0]       mem_wdata, mem_rdata;

  lsu #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .a_rst(a_rst),
    .iss_valid(iss_valid), .iss_ld(iss_ld), .iss_st(iss_st), .iss_width(iss_width),
    .iss_addr(iss_addr), .iss_data(iss_data), .iss_tag(iss_tag), .iss_ready(iss_ready),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .lsu_data(lsu_data), .lsu_wb(lsu_wb), .lsu_tag(lsu_tag), .lsu_st_pending(lsu_st_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] bus_mem [65536];
  logic [7:0] ref_mem [65536];
  int   total, bad, wb_seen;
  int   waits_cfg, wait_cnt;
  bit   force_stall;

  typedef struct { logic [15:0] data; logic [TAG_W-1:0] tag; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic ld; logic st; logic wd;
    logic [15:0] addr; logic [15:0] data; logic [TAG_W-1:0] tag;
    int waits; logic [15:0] exp;
  } vec_t;
  vec_t vt[9];

  assign mem_ready = !force_stall && (wait_cnt == 0);
  assign mem_rdata = bus_mem[mem_addr];

  // Bus responder: commits writes and counts down wait states per bus cycle.
  always @(posedge clk) begin
    if ((mem_rd || mem_wr) && mem_ready) begin
      if (mem_wr) bus_mem[mem_addr] = mem_wdata;
      wait_cnt <= waits_cfg;
    end else if ((mem_rd || mem_wr) && wait_cnt != 0) begin
      wait_cnt <= wait_cnt - 1;
    end else if (!(mem_rd || mem_wr)) begin
      wait_cnt <= waits_cfg;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!a_rst) begin
      chk("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
      if (lsu_wb) begin
        wb_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_wb", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wb_data", 32'(lsu_data), 32'(e.data));
          chk("wb_tag", 32'(lsu_tag), 32'(e.tag));
        end
      end
    end
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] v);
    bus_mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic ld, input logic st, input logic wd, input logic [15:0] a,
                       input logic [15:0] d, input logic [TAG_W-1:0] t, input logic [15:0] exp);
    int n;
    iss_valid = 1'b1; iss_ld = ld; iss_st = st; iss_width = wd;
    iss_addr = a; iss_data = d; iss_tag = t;
    n = 0;
    while (!iss_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!iss_ready) begin
      chk("issue_timeout", 32'd0, 32'd1);
      iss_valid = 1'b0;
    end else begin
      if (!(st && !ld)) sb.push_back('{data: exp, tag: t});
      @(negedge clk);
      iss_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || lsu_st_pending || mem_rd || mem_wr) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 400), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int wb0;
    logic        r_st, r_wd;
    logic [15:0] r_a, r_d, r_e;
    total = 0; bad = 0; wb_seen = 0;
    waits_cfg = 0; wait_cnt = 0; force_stall = 1'b0;
    iss_valid = 1'b0; iss_ld = 1'b0; iss_st = 1'b0; iss_width = 1'b0;
    iss_addr = '0; iss_data = '0; iss_tag = '0;
    for (int i = 0; i < 65536; i++) begin
      bus_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    preload(16'h1234, 8'hA5);
    preload(16'hFFFF, 8'h34);
    preload(16'h0000, 8'h12);
    preload(16'h0100, 8'h5A);
    preload(16'h0101, 8'hC3);
    for (int i = 0; i < 16; i++) preload(16'h0400 + 16'(i), 8'(8'h30 + i * 7));

    vt[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 2'd1, 0, 16'h00A5};
    vt[1] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 2'd2, 0, 16'h1234};
    vt[2] = '{1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000, 2'd3, 1, 16'hC35A};
    vt[3] = '{1'b0, 1'b1, 1'b1, 16'h0300, 16'h7788, 2'd0, 0, 16'h0000};
    vt[4] = '{1'b1, 1'b0, 1'b1, 16'h0300, 16'h0000, 2'd1, 2, 16'h7788};
    vt[5] = '{1'b0, 1'b1, 1'b0, 16'h0301, 16'h1199, 2'd2, 1, 16'h0000};
    vt[6] = '{1'b1, 1'b0, 1'b1, 16'h0300, 16'h0000, 2'd3, 0, 16'h9988};
    vt[7] = '{1'b1, 1'b0, 1'b0, 16'h0301, 16'h0000, 2'd0, 1, 16'h0099};
    vt[8] = '{1'b1, 1'b1, 1'b0, 16'h1234, 16'h5555, 2'd2, 0, 16'h00A5};

    // Reset values
    a_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_iss_ready", 32'(iss_ready), 32'd1);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_lsu_data", 32'(lsu_data), 32'd0);
    chk("rst_lsu_wb", 32'(lsu_wb), 32'd0);
    chk("rst_lsu_tag", 32'(lsu_tag), 32'd0);
    chk("rst_st_pending", 32'(lsu_st_pending), 32'd0);
    a_rst = 1'b0;
    @(negedge clk);

    // Byte load timing: pop at E1, wb at E2
    issue(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0, 2'd1, 16'h00A5);
    chk("bl_e0_rd", 32'(mem_rd), 32'd0);
    @(negedge clk);
    chk("bl_e1_rd", 32'(mem_rd), 32'd1);
    chk("bl_e1_addr", 32'(mem_addr), 32'h1234);
    @(negedge clk);
    chk("bl_e2_wb", 32'(lsu_wb), 32'd1);
    chk("bl_e2_data", 32'(lsu_data), 32'h00A5);
    chk("bl_e2_tag", 32'(lsu_tag), 32'd1);
    @(negedge clk);
    chk("bl_e3_wb", 32'(lsu_wb), 32'd0);
    drain();

    // Word load across the address wrap
    wb0 = wb_seen;
    issue(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0, 2'd2, 16'h1234);
    @(negedge clk);
    chk("wl_lo_rd", 32'(mem_rd), 32'd1);
    chk("wl_lo_addr", 32'(mem_addr), 32'hFFFF);
    @(negedge clk);
    chk("wl_hi_rd", 32'(mem_rd), 32'd1);
    chk("wl_hi_addr", 32'(mem_addr), 32'h0000);
    @(negedge clk);
    chk("wl_wb", 32'(lsu_wb), 32'd1);
    @(negedge clk);
    chk("wl_wb_drop", 32'(lsu_wb), 32'd0);
    drain();
    chk("wl_single_wb", 32'(wb_seen - wb0), 32'd1);

    // Word store with two wait states on the low byte
    wb0 = wb_seen;
    issue(1'b0, 1'b1, 1'b1, 16'h0200, 16'hBEEF, 2'd3, 16'h0);
    force_stall = 1'b1;
    chk("ws_pending_q", 32'(lsu_st_pending), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ws_lo_wr", 32'(mem_wr), 32'd1);
      chk("ws_lo_addr", 32'(mem_addr), 32'h0200);
      chk("ws_lo_wdata", 32'(mem_wdata), 32'h00EF);
      if (i == 2) force_stall = 1'b0;
    end
    @(negedge clk);
    chk("ws_hi_wr", 32'(mem_wr), 32'd1);
    chk("ws_hi_addr", 32'(mem_addr), 32'h0201);
    chk("ws_hi_wdata", 32'(mem_wdata), 32'h00BE);
    @(negedge clk);
    chk("ws_done_wr", 32'(mem_wr), 32'd0);
    chk("ws_done_pending", 32'(lsu_st_pending), 32'd0);
    chk("ws_mem_lo", 32'(bus_mem[16'h0200]), 32'h00EF);
    chk("ws_mem_hi", 32'(bus_mem[16'h0201]), 32'h00BE);
    chk("ws_no_wb", 32'(wb_seen - wb0), 32'd0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      waits_cfg = vt[i].waits;
      issue(vt[i].ld, vt[i].st, vt[i].wd, vt[i].addr, vt[i].data, vt[i].tag, vt[i].exp);
      drain();
      if (!(vt[i].st && !vt[i].ld)) begin
        chk("vec_hold_data", 32'(lsu_data), 32'(vt[i].exp));
        chk("vec_hold_tag", 32'(lsu_tag), 32'(vt[i].tag));
      end
    end
    waits_cfg = 0;

    // Back-to-back issues against a stalled bus
    force_stall = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0, 2'd1, 16'h00A5);
    issue(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0, 2'd2, 16'h005A);
    issue(1'b1, 1'b0, 1'b0, 16'h0101, 16'h0, 2'd3, 16'h00C3);
    chk("full_ready0", 32'(iss_ready), 32'd0);
    @(negedge clk);
    chk("full_ready1", 32'(iss_ready), 32'd0);
    @(negedge clk);
    chk("full_ready2", 32'(iss_ready), 32'd0);
    force_stall = 1'b0;
    @(negedge clk);
    chk("full_wb_ready", 32'(iss_ready), 32'd0);
    @(negedge clk);
    chk("full_pop_ready", 32'(iss_ready), 32'd1);
    drain();

    // Randomised in-order stream checked against a byte reference model
    for (int i = 0; i < 24; i++) begin
      r_st = 1'($urandom_range(0, 1));
      r_wd = 1'($urandom_range(0, 1));
      r_a  = 16'h0400 + 16'($urandom_range(0, 7));
      r_d  = 16'($urandom);
      r_e  = r_wd ? {ref_mem[r_a + 16'd1], ref_mem[r_a]} : {8'h00, ref_mem[r_a]};
      if (r_st) begin
        ref_mem[r_a] = r_d[7:0];
        if (r_wd) ref_mem[r_a + 16'd1] = r_d[15:8];
      end
      waits_cfg = $urandom_range(0, 2);
      issue(~r_st, r_st, r_wd, r_a, r_d, TAG_W'(i), r_e);
    end
    drain();
    waits_cfg = 0;
    for (int i = 0; i < 16; i++) begin
      chk("rand_mem", 32'(bus_mem[16'h0400 + 16'(i)]), 32'(ref_mem[16'h0400 + 16'(i)]));
    end

    // Reset during the high byte of a word load
    issue(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0, 2'd2, 16'hC35A);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hi_rd", 32'(mem_rd), 32'd1);
    chk("rst_hi_addr", 32'(mem_addr), 32'h0101);
    a_rst = 1'b1;
    #1;
    chk("rst_async_rd", 32'(mem_rd), 32'd0);
    chk("rst_async_wr", 32'(mem_wr), 32'd0);
    chk("rst_async_ready", 32'(iss_ready), 32'd1);
    chk("rst_async_addr", 32'(mem_addr), 32'd0);
    sb.delete();
    wb0 = wb_seen;
    @(negedge clk);
    a_rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_no_wb", 32'(wb_seen - wb0), 32'd0);
    chk("rst_idle_rd", 32'(mem_rd), 32'd0);
    chk("rst_lsu_data_clr", 32'(lsu_data), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
